// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a single-outstanding
// imem req/ack link, fills IF/ID and applies execute-stage redirects.
//
// imem handshake: imemReq is the valid, imemAck is the ready/response. Once
// imemReq rises, imemAddr stays fixed until the cycle in which imemAck=1
// (that edge completes the transfer and imemRdata is captured). imemAck while
// imemReq=0 is ignored.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  pcSrcE,
    input  logic [31:0] pcTargetE,
    input  logic [31:0] aluResultE,
    input  logic        stallD,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemRdata,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic [31:0] pcPlus4D,
    output logic        validD,
    output logic        misalignE,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_DROP = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic [31:0] raw_target;
    logic [31:0] aligned_target;
    logic        redir;
    logic        req_active;
    logic        ack_ok;
    logic [31:0] req_addr_plus4;
    logic [31:0] skid_pc_plus4;

    // JALR clears bit 0 first; bit 1 of what remains is the misalignment flag.
    always_comb begin
        raw_target = pcTargetE;
        if (pcSrcE == 2'b11) begin
            raw_target = aluResultE & ~32'h1;
        end
    end

    assign redir          = (pcSrcE != 2'b00);
    assign aligned_target = raw_target & ~32'h3;
    assign misalignE      = redir & raw_target[1];

    assign req_active     = ~reset & (state_q != ST_HOLD);
    assign ack_ok         = imemAck & req_active;
    assign req_addr_plus4 = req_addr_q + 32'd4;
    assign skid_pc_plus4  = skid_pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_f_d       = pc_f_q;
        req_addr_d   = req_addr_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;

        if (redir) begin
            pc_f_d       = aligned_target;
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            skid_valid_d = 1'b0;
            // An unacked request cannot be withdrawn, so its response is dropped.
            if (!ack_ok && (state_q != ST_HOLD)) begin
                state_d = ST_DROP;
            end else begin
                state_d    = ST_WAIT;
                req_addr_d = aligned_target;
            end
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (ack_ok) begin
                        pc_f_d = req_addr_plus4;
                        if (!stallD) begin
                            ifid_instr_d = imemRdata;
                            ifid_pc_d    = req_addr_q;
                            ifid_pc4_d   = req_addr_plus4;
                            ifid_valid_d = 1'b1;
                            req_addr_d   = req_addr_plus4;
                        end else begin
                            skid_instr_d = imemRdata;
                            skid_pc_d    = req_addr_q;
                            skid_valid_d = 1'b1;
                            state_d      = ST_HOLD;
                        end
                    end else if (!stallD) begin
                        ifid_valid_d = 1'b0;
                        ifid_instr_d = NOP_INSTR;
                    end
                end
                ST_DROP: begin
                    if (ack_ok) begin
                        req_addr_d = pc_f_q;
                        state_d    = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (!stallD) begin
                        ifid_instr_d = skid_instr_q;
                        ifid_pc_d    = skid_pc_q;
                        ifid_pc4_d   = skid_pc_plus4;
                        ifid_valid_d = skid_valid_q;
                        skid_valid_d = 1'b0;
                        req_addr_d   = pc_f_q;
                        state_d      = ST_WAIT;
                    end
                end
                default: begin
                    state_d = ST_WAIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_WAIT;
            pc_f_q       <= RESET_PC;
            req_addr_q   <= RESET_PC;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'h0;
            skid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= 32'h0;
            ifid_pc4_q   <= 32'h0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_f_q       <= pc_f_d;
            req_addr_q   <= req_addr_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign imemReq   = req_active;
    assign imemAddr  = req_addr_q;
    assign instrD    = ifid_instr_q;
    assign pcD       = ifid_pc_q;
    assign pcPlus4D  = ifid_pc4_q;
    assign validD    = ifid_valid_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a latency-programmable instruction memory plus a
// program-order model of which PC decode must see next.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  pcSrcE = 2'b00;
    logic [31:0] pcTargetE = 32'h0;
    logic [31:0] aluResultE = 32'h0;
    logic        stallD = 1'b0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck = 1'b0;
    logic [31:0] imemRdata = 32'h0;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] pcPlus4D;
    logic        validD;
    logic        misalignE;
    logic [1:0]  dbg_state;

    fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk        (clk),
        .reset      (reset),
        .pcSrcE     (pcSrcE),
        .pcTargetE  (pcTargetE),
        .aluResultE (aluResultE),
        .stallD     (stallD),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemAck    (imemAck),
        .imemRdata  (imemRdata),
        .instrD     (instrD),
        .pcD        (pcD),
        .pcPlus4D   (pcPlus4D),
        .validD     (validD),
        .misalignE  (misalignE),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // stimulus controls
    int          lat_fix = 0;
    bit          rnd_mode = 1'b0;
    bit          stall_val = 1'b0;
    logic [1:0]  frc_src = 2'b00;
    logic [31:0] frc_tgt = 32'h0;
    logic [31:0] frc_alu = 32'h0;
    bit          arm_en = 1'b0;
    bit          arm_fired = 1'b0;
    logic [31:0] arm_addr = 32'h0;
    logic [1:0]  arm_src = 2'b00;
    logic [31:0] arm_tgt = 32'h0;

    // observations and model state
    logic        obs_req, obs_valid, obs_mis;
    logic [31:0] obs_addr, obs_pc;
    logic        drv_ack = 1'b0;
    logic [31:0] exp_pc = RST_PC;
    bit          prev_pending = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    int          mem_cnt = 0;
    int          consumed = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int pick_lat();
        if (lat_fix < 0) return int'($urandom_range(0, 3));
        return lat_fix;
    endfunction

    // One cycle: entered just after a falling edge, leaves at the next one.
    task automatic step();
        logic [31:0] raw;
        logic        redir_now;
        #1;
        obs_req   = imemReq;
        obs_addr  = imemAddr;
        obs_valid = validD;
        obs_pc    = pcD;
        if (reset) begin
            check_eq("req_in_reset", imemReq, 1'b0);
        end else if (prev_pending) begin
            check_eq("req_held", imemReq, 1'b1);
            check_eq("addr_held", imemAddr, prev_addr);
        end
        if (imemReq) check_eq("addr_align", imemAddr[1:0], 2'b00);
        if (!validD) check_eq("bubble_nop", instrD, NOP);
        if (validD && !reset) begin
            check_eq("pcD", pcD, exp_pc);
            check_eq("instrD", instrD, mem_word(exp_pc));
            check_eq("pcPlus4D", pcPlus4D, exp_pc + 32'd4);
        end

        if (reset) begin
            imemAck   = 1'b0;
            imemRdata = $urandom;
            mem_cnt   = pick_lat();
        end else if (imemReq) begin
            if (mem_cnt == 0) begin
                imemAck   = 1'b1;
                imemRdata = mem_word(imemAddr);
                mem_cnt   = pick_lat();
            end else begin
                imemAck   = 1'b0;
                imemRdata = $urandom;
                mem_cnt--;
            end
        end else begin
            imemAck   = 1'($urandom_range(0, 1));
            imemRdata = $urandom;
        end
        drv_ack = imemAck;

        pcSrcE     = 2'b00;
        pcTargetE  = $urandom;
        aluResultE = $urandom;
        stallD     = stall_val;
        if (rnd_mode) begin
            stallD = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) begin
                pcSrcE = 2'($urandom_range(1, 3));
                if ($urandom_range(0, 3) == 0) begin
                    pcTargetE  = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                    aluResultE = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                end
            end
        end
        if (frc_src != 2'b00) begin
            pcSrcE     = frc_src;
            pcTargetE  = frc_tgt;
            aluResultE = frc_alu;
            frc_src    = 2'b00;
        end
        if (arm_en && imemReq && !imemAck && imemAddr == arm_addr) begin
            pcSrcE    = arm_src;
            pcTargetE = arm_tgt;
            arm_en    = 1'b0;
            arm_fired = 1'b1;
        end
        if (reset) pcSrcE = 2'b00;
        #1;
        raw       = (pcSrcE == 2'b11) ? (aluResultE & ~32'h1) : pcTargetE;
        redir_now = (pcSrcE != 2'b00);
        check_eq("misalignE", misalignE, redir_now && raw[1]);
        obs_mis = misalignE;

        if (reset) begin
            exp_pc = RST_PC;
        end else if (redir_now) begin
            exp_pc = raw & ~32'h3;
        end else if (validD && !stallD) begin
            exp_pc = exp_pc + 32'd4;
            consumed++;
        end
        prev_pending = !reset && imemReq && !imemAck;
        prev_addr    = imemAddr;
        @(negedge clk);
    endtask

    task automatic expect_next_addr(input string tag, input logic [31:0] start,
                                    input logic [31:0] exp, input bit bubble_chk);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 24 && !found; i++) begin
            step();
            if (obs_req && obs_addr != start) begin
                check_eq(tag, obs_addr, exp);
                found = 1'b1;
            end else if (bubble_chk) begin
                check_eq({tag, "_bubble"}, obs_valid, 1'b0);
            end
        end
        check_eq({tag, "_timeout"}, found, 1'b1);
    endtask

    initial begin
        int n0, ones;
        logic pa;
        logic [31:0] start;

        @(negedge clk);
        repeat (3) step();
        check_eq("rst_req", imemReq, 1'b0);
        check_eq("rst_valid", validD, 1'b0);
        check_eq("rst_instr", instrD, NOP);
        check_eq("rst_pcD", pcD, 32'h0);
        check_eq("rst_pc4", pcPlus4D, 32'h0);

        // back-to-back fetch with an always-ready memory
        reset = 1'b0;
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("a_addr", obs_addr, exp_q.pop_front());
            check_eq("a_valid", obs_valid, k > 0);
            if (k > 0) check_eq("a_pcD", obs_pc, 32'(4 * (k - 1)));
        end

        // 3-cycle ack latency: valid exactly the cycle after each ack
        lat_fix = 2;
        repeat (4) step();
        ones = 0;
        for (int i = 0; i < 9; i++) begin
            pa = drv_ack;
            step();
            check_eq("b_valid_after_ack", obs_valid, pa);
            ones += int'(obs_valid);
        end
        check_eq("b_rate", ones, 3);

        // stall with an ack landing in the first stalled cycle
        lat_fix = 0;
        repeat (4) step();
        stall_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i > 0) check_eq("c_req_hold", obs_req, 1'b0);
            check_eq("c_valid_hold", obs_valid, 1'b1);
        end
        stall_val = 1'b0;
        n0 = consumed;
        repeat (3) step();
        check_eq("c_release_count", consumed - n0, 3);

        // branch issued while a request for 0x20 is still unacked
        lat_fix  = 3;
        frc_src  = 2'b01;
        frc_tgt  = 32'h20;
        arm_addr = 32'h20;
        arm_src  = 2'b10;
        arm_tgt  = 32'h100;
        arm_en   = 1'b1;
        for (int i = 0; i < 40 && !arm_fired; i++) step();
        check_eq("d_armed", arm_fired, 1'b1);
        expect_next_addr("d_next_req", 32'h20, 32'h100, 1'b1);
        repeat (8) step();

        // JALR targets: bit 0 cleared, bit 1 flagged
        lat_fix = 1;
        frc_src = 2'b11;
        frc_alu = 32'h203;
        step();
        check_eq("e_mis_203", obs_mis, 1'b1);
        expect_next_addr("e_addr_203", obs_addr, 32'h200, 1'b0);
        repeat (4) step();
        frc_src = 2'b11;
        frc_alu = 32'h201;
        step();
        check_eq("e_mis_201", obs_mis, 1'b0);
        expect_next_addr("e_addr_201", obs_addr, 32'h200, 1'b0);
        repeat (6) step();

        // redirect together with stall while the skid buffer is full
        lat_fix = 0;
        repeat (3) step();
        stall_val = 1'b1;
        step();
        step();
        frc_src = 2'b01;
        frc_tgt = 32'h300;
        step();
        step();
        check_eq("f_flushed", obs_valid, 1'b0);
        check_eq("f_req", obs_req, 1'b1);
        check_eq("f_addr", obs_addr, 32'h300);
        stall_val = 1'b0;
        repeat (5) step();

        // PC wrap-around
        frc_src = 2'b01;
        frc_tgt = 32'hFFFF_FFF8;
        repeat (8) step();

        // randomized traffic with one mid-run reset
        rnd_mode = 1'b1;
        lat_fix  = -1;
        n0 = consumed;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                reset = 1'b1;
                step();
                step();
                reset = 1'b0;
            end
            step();
        end
        check_eq("throughput", (consumed - n0) >= 200, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
